t_press_pulse_gen: RTL
======================

// Module: t_press_pulse_gen
// PURPOSE
// - Upstream stage of the T flip-flop (module t). Converts a raw, bouncy, asynchronous push-button into clean toggle commands.
// - Synchronizes input b, debounces press and release, and emits a single-cycle pulse on t for each validated press.
// - t drives the T flip-flop's t input directly; both blocks share clock c.
// - Also exports the debounced level db and a wrapping press counter pcnt.
// PARAMETERS
// - DB_CYCLES      4   consecutive stable samples required to accept a press/release (legal: 1..2**DB_W)
// - DB_W           8   width of debounce counter dcnt
// - REPEAT_CYCLES  16  auto-repeat interval in cycles (used only with AUTO_REPEAT_EN; >=1)
// - RPT_W          8   width of repeat counter rcnt (used only with AUTO_REPEAT_EN)
// PORTS
// - c     in   1  clock, rising edge
// - rst   in   1  reset, synchronous, active-high
// - b     in   1  raw button, asynchronous to c, may bounce
// - t     out  1  toggle pulse, exactly one cycle high per accepted press
// - db    out  1  debounced button level
// - pcnt  out  8  accepted-press count (includes repeat pulses), wraps 255->0
// BEHAVIOUR
// - Reset: s1=s2=0, state=IDLE, dcnt=0, rcnt=0, t=0, db=0, pcnt=0.
// - rst high at any edge overrides everything, including mid-debounce and a pulse in flight; t drops at that same edge.
// - All outputs are registered. No combinational path from b to any output.
// - Synchronizer: s1<=b, s2<=s1. The FSM sees only s2 (2-cycle latency).
// - FSM, evaluated at each rising edge of c:
//   - IDLE (db=0): s2=1 -> ARM, dcnt<=0.
//   - ARM: s2=0 -> IDLE (bounce rejected, no pulse).
//     - s2=1 and dcnt==DB_CYCLES-1 -> HELD; t<=1, db<=1, pcnt<=pcnt+1, rcnt<=0.
//     - otherwise dcnt<=dcnt+1.
//   - HELD (db=1): s2=0 -> REL, dcnt<=0.
//   - REL: s2=1 -> HELD (release bounce rejected, no new pulse, db stays 1).
//     - s2=0 and dcnt==DB_CYCLES-1 -> IDLE, db<=0.
//     - otherwise dcnt<=dcnt+1.
// - t is high for exactly one cycle and cleared on the following edge unless another pulse is due.
// - Latency: if b rises and then stays stable, and edge 1 is the first edge that samples b=1:
//   - t and db rise at edge DB_CYCLES+3 (edge 7 for the default).
//   - db falls at edge DB_CYCLES+3 after b falls stably.
// - A high or low glitch lasting fewer than DB_CYCLES+1 synchronized samples changes no output.
// - pcnt is an 8-bit modulo counter: 255+1 -> 0, with no saturation or flag.
// - dcnt never exceeds DB_CYCLES-1.
// - With DB_CYCLES=1: ARM accepts on its first s2=1 sample.
// CONFIGURATION
// - Macro AUTO_REPEAT_EN. When defined:
//   - In HELD with s2=1, rcnt increments each cycle.
//   - When rcnt==REPEAT_CYCLES-1: t<=1, pcnt<=pcnt+1, rcnt<=0.
//   - rcnt is cleared on entry to HELD, and frozen in REL.
//   - A release-bounce return REL->HELD resumes counting from the frozen value.
//   - First repeat pulse comes REPEAT_CYCLES cycles after the press pulse.
// - When not defined:
//   - rcnt and its logic are absent.
//   - Exactly one t pulse per accepted press regardless of hold time.
//   - REPEAT_CYCLES and RPT_W are ignored.
// TESTING
// - Clock c period 20 ns. rst=1 for 3 edges, then 0.
// - 1. Reset: drive b=1 during rst -> t=0, db=0, pcnt=0 throughout reset; press accepted normally after release of rst.
// - 2. Clean press: b 0->1, held 20 cycles
//   - t high exactly one cycle at edge 7, db=1 from edge 7, pcnt=1.
//   - release: db=0 seven edges after b falls, no t pulse.
// - 3. Bounce: b toggles 1,0,1,0 every 2 cycles, then stable 1 -> exactly one t pulse, 7 edges after the final rise; pcnt=1.
// - 4. Release bounce: while HELD, b low 2 cycles, then high -> db stays 1, no t pulse, pcnt unchanged.
// - 5. Wrap: 256 clean presses -> pcnt reads 0 after the 256th, and 256 t pulses are counted.
// - 6. Mid-operation reset: assert rst in ARM with dcnt=2 -> next edge IDLE, all outputs 0; b still high re-arms after rst falls.
// - 6a. (AUTO_REPEAT_EN) Hold b high 60 cycles after acceptance -> repeat t pulses at +16, +32, +48 cycles; pcnt=4.

Source files
------------

// File: rtl/t_press_pulse_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : t_press_pulse_gen_if
// Brief    : Button-side bus of the press pulse generator (raw button in,
//            toggle pulse / debounced level / press count out).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface t_press_pulse_gen_if;
  logic       b;
  logic       t;
  logic       db;
  logic [7:0] pcnt;

  modport master (output b, input  t, input  db, input  pcnt);
  modport slave  (input  b, output t, output db, output pcnt);
endinterface
`default_nettype wire

// File: rtl/t_press_pulse_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : t_press_pulse_gen
// Brief    : Synchronizes and debounces a raw push-button and emits one t pulse
//            per accepted press. Optional macro AUTO_REPEAT_EN adds auto-repeat.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module t_press_pulse_gen #(
  parameter int DB_CYCLES     = 4,
  parameter int DB_W          = 8,
  parameter int REPEAT_CYCLES = 16,
  parameter int RPT_W         = 8
) (
  input  wire logic           c,
  input  wire logic           rst,
  t_press_pulse_gen_if.slave  bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_arm  = 2'd1;
  localparam logic [1:0] c_held = 2'd2;
  localparam logic [1:0] c_rel  = 2'd3;

  localparam logic [DB_W-1:0] c_db_last = DB_W'(DB_CYCLES - 1);

  // Empty on legal parameter sets; a non-empty elaboration here flags misuse.
  if (DB_CYCLES < 1 || REPEAT_CYCLES < 1 || RPT_W < 1) begin : g_cfg_illegal
  end

  logic            r_s1;
  logic            r_s2;
  logic [1:0]      r_state;
  logic [DB_W-1:0] r_dcnt;
  logic            r_t;
  logic            r_db;
  logic [7:0]      r_pcnt;

`ifdef AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] c_rpt_last = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rcnt;
`endif

  always_ff @(posedge c) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= c_idle;
      r_dcnt  <= '0;
      r_t     <= 1'b0;
      r_db    <= 1'b0;
      r_pcnt  <= 8'd0;
`ifdef AUTO_REPEAT_EN
      r_rcnt  <= '0;
`endif
    end else begin
      r_s1 <= bus.b;
      r_s2 <= r_s1;
      r_t  <= 1'b0;
      case (r_state)
        c_idle: begin
          if (r_s2) begin
            r_state <= c_arm;
            r_dcnt  <= '0;
          end
        end
        c_arm: begin
          if (!r_s2) begin
            r_state <= c_idle;
          end else if (r_dcnt == c_db_last) begin
            r_state <= c_held;
            r_t     <= 1'b1;
            r_db    <= 1'b1;
            r_pcnt  <= r_pcnt + 8'd1;
`ifdef AUTO_REPEAT_EN
            r_rcnt  <= '0;
`endif
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        c_held: begin
          if (!r_s2) begin
            r_state <= c_rel;
            r_dcnt  <= '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (r_rcnt == c_rpt_last) begin
            r_t    <= 1'b1;
            r_pcnt <= r_pcnt + 8'd1;
            r_rcnt <= '0;
          end else begin
            r_rcnt <= r_rcnt + 1'b1;
          end
`endif
        end
        c_rel: begin
          // rcnt is left untouched here so a bounce back to HELD resumes it.
          if (r_s2) begin
            r_state <= c_held;
          end else if (r_dcnt == c_db_last) begin
            r_state <= c_idle;
            r_db    <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.t    = r_t;
  assign bus.db   = r_db;
  assign bus.pcnt = r_pcnt;

endmodule
`default_nettype wire
